// File: rtl/pwm_seq_pkg.sv
// Shared definitions for the PWM mode sequencer.
//   state_t       : sequencer FSM states (IDLE, ARM, RUN)
//   END_MODE      : mode value marking end of program in the step table
//   PG_RST_ACTIVE : asserted level of the pulse_generator reset
package pwm_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2
  } state_t;

  localparam logic [3:0] END_MODE      = 4'd0;
  localparam logic       PG_RST_ACTIVE = 1'b1;

endpackage

// File: rtl/pwm_seq_table.sv
// Step program table: NSTEPS entries of {mode, duration}.
//   clk                        : write clock
//   wr_en/wr_addr/wr_mode/wr_dur : single write port
//   rd_addr -> rd_mode/rd_dur  : combinational read port
// Contents are not reset; the host programs the table before starting.
// A read in the same cycle as a write returns the old contents.
module pwm_seq_table #(
  parameter int NSTEPS = 8,
  parameter int AW     = 3,
  parameter int DURW   = 8
) (
  input  logic            clk,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [3:0]      wr_mode,
  input  logic [DURW-1:0] wr_dur,
  input  logic [AW-1:0]   rd_addr,
  output logic [3:0]      rd_mode,
  output logic [DURW-1:0] rd_dur
);

  logic [3:0]      mode_mem [NSTEPS];
  logic [DURW-1:0] dur_mem  [NSTEPS];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mode_mem[wr_addr] <= wr_mode;
      dur_mem[wr_addr]  <= wr_dur;
    end
  end

  assign rd_mode = mode_mem[rd_addr];
  assign rd_dur  = dur_mem[rd_addr];

endmodule

// File: rtl/pwm_mode_sequencer.sv
// Plays a programmed list of (mode, duration) steps into a pulse_generator,
// switching modes only on PWM period boundaries (pg_count wrapping to 0).
//   clk, rst (async, active-low)
//   wr_en/wr_addr/wr_mode/wr_dur : table programming (IDLE only, else wr_err)
//   start/stop/loop_en           : program control
//   pg_count                     : count from the driven pulse_generator
//   pg_mode/pg_rst               : registered drive to the pulse_generator
//   busy, step_idx, done, wr_err : status
module pwm_mode_sequencer
  import pwm_seq_pkg::*;
#(
  parameter int NSTEPS = 8,
  parameter int AW     = 3,
  parameter int DURW   = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [3:0]      wr_mode,
  input  logic [DURW-1:0] wr_dur,
  input  logic            start,
  input  logic            stop,
  input  logic            loop_en,
  input  logic [15:0]     pg_count,
  output logic [3:0]      pg_mode,
  output logic            pg_rst,
  output logic            busy,
  output logic [AW-1:0]   step_idx,
  output logic            done,
  output logic            wr_err
);

  state_t          state;
  logic [15:0]     prev_count;
  logic            bnd;
  logic [DURW-1:0] per_cnt;
  logic [DURW-1:0] cur_dur;
  logic [DURW-1:0] dur0;
  logic [3:0]      mode0;
  logic [AW-1:0]   rd_addr;
  logic [3:0]      rd_mode;
  logic [DURW-1:0] rd_dur;
  logic [DURW-1:0] dur_eff;
  logic [DURW:0]   cnt_inc;
  logic            period_end;
  logic            last_step;

  // One read port: entry 0 while idle (start latch), otherwise the next step.
  // Entry 0 is kept in mode0/dur0 so a loop restart needs no second read.
  assign rd_addr = (state == IDLE) ? '0 : step_idx + AW'(1);

  pwm_seq_table #(
    .NSTEPS (NSTEPS),
    .AW     (AW),
    .DURW   (DURW)
  ) u_table (
    .clk     (clk),
    .wr_en   (wr_en && (state == IDLE)),
    .wr_addr (wr_addr),
    .wr_mode (wr_mode),
    .wr_dur  (wr_dur),
    .rd_addr (rd_addr),
    .rd_mode (rd_mode),
    .rd_dur  (rd_dur)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) prev_count <= '0;
    else      prev_count <= pg_count;
  end

  assign bnd        = (pg_count == 16'd0) && (prev_count != 16'd0);
  assign dur_eff    = (cur_dur == '0) ? DURW'(1) : cur_dur;
  assign cnt_inc    = {1'b0, per_cnt} + (DURW+1)'(1);
  assign period_end = (cnt_inc == {1'b0, dur_eff});
  assign last_step  = (step_idx == AW'(NSTEPS - 1)) || (rd_mode == END_MODE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      pg_mode  <= END_MODE;
      pg_rst   <= PG_RST_ACTIVE;
      busy     <= 1'b0;
      step_idx <= '0;
      done     <= 1'b0;
      wr_err   <= 1'b0;
      per_cnt  <= '0;
      cur_dur  <= '0;
      dur0     <= '0;
      mode0    <= END_MODE;
    end else begin
      done   <= 1'b0;
      wr_err <= wr_en && (state != IDLE);
      case (state)
        IDLE: begin
          if (start && !stop) begin
            mode0    <= rd_mode;
            dur0     <= rd_dur;
            cur_dur  <= rd_dur;
            step_idx <= '0;
            per_cnt  <= '0;
            if (rd_mode == END_MODE) begin
              done <= 1'b1;
            end else begin
              state   <= ARM;
              pg_mode <= rd_mode;
              pg_rst  <= ~PG_RST_ACTIVE;
              busy    <= 1'b1;
            end
          end
        end
        ARM: begin
          if (stop) begin
            state    <= IDLE;
            pg_mode  <= END_MODE;
            pg_rst   <= PG_RST_ACTIVE;
            busy     <= 1'b0;
            step_idx <= '0;
          end else if (bnd) begin
            state   <= RUN;
            per_cnt <= '0;
          end
        end
        RUN: begin
          if (stop) begin
            state    <= IDLE;
            pg_mode  <= END_MODE;
            pg_rst   <= PG_RST_ACTIVE;
            busy     <= 1'b0;
            step_idx <= '0;
          end else if (bnd) begin
            if (period_end) begin
              per_cnt <= '0;
              if (last_step) begin
                if (loop_en) begin
                  step_idx <= '0;
                  pg_mode  <= mode0;
                  cur_dur  <= dur0;
                end else begin
                  state    <= IDLE;
                  pg_mode  <= END_MODE;
                  pg_rst   <= PG_RST_ACTIVE;
                  busy     <= 1'b0;
                  step_idx <= '0;
                  done     <= 1'b1;
                end
              end else begin
                step_idx <= rd_addr;
                pg_mode  <= rd_mode;
                cur_dur  <= rd_dur;
              end
            end else begin
              per_cnt <= per_cnt + DURW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_mode_sequencer.sv
module tb_pwm_mode_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [3:0]  wr_mode;
  logic [7:0]  wr_dur;
  logic        start;
  logic        stop;
  logic        loop_en;
  logic [15:0] pg_count;
  logic [3:0]  pg_mode;
  logic        pg_rst;
  logic        busy;
  logic [2:0]  step_idx;
  logic        done;
  logic        wr_err;

  pwm_mode_sequencer #(.NSTEPS(8), .AW(3), .DURW(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_mode  (wr_mode),
    .wr_dur   (wr_dur),
    .start    (start),
    .stop     (stop),
    .loop_en  (loop_en),
    .pg_count (pg_count),
    .pg_mode  (pg_mode),
    .pg_rst   (pg_rst),
    .busy     (busy),
    .step_idx (step_idx),
    .done     (done),
    .wr_err   (wr_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0][3:0] m;
    logic [7:0][7:0] d;
    logic            lp;
    logic [3:0]      stop_at;
    logic [3:0]      n;
    logic [11:0][7:0] ex;   // {step_idx, mode} per PWM period
    logic            exp_done;
  } vec_t;

  vec_t vecs [5];
  int   total = 0;
  int   bad   = 0;
  int   per   = 3;
  int   expm [$];
  int   expi [$];

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  // Generator stand-in: counts 0..per-1 while released, held at 0 in reset.
  task automatic tick();
    @(posedge clk);
    #1;
    if (pg_rst) pg_count = '0;
    else if (int'(pg_count) + 1 >= per) pg_count = '0;
    else pg_count = pg_count + 16'd1;
  endtask

  task automatic load(input logic [7:0][3:0] m, input logic [7:0][7:0] d);
    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1; wr_addr = i[2:0]; wr_mode = m[i]; wr_dur = d[i];
      tick();
    end
    wr_en = 1'b0;
    check("idle_write_no_err", wr_err, 0);
    tick();
  endtask

  // Reference: one ARM period of step 0, then each step for max(dur,1)
  // periods, ending at the marker / table end (or wrapping when looping).
  function automatic void build(input logic [7:0][3:0] m, input logic [7:0][7:0] d,
                                input logic lp, input int cap);
    int k = 0;
    int reps;
    expm.delete(); expi.delete();
    if (m[0] == 4'd0) return;
    expm.push_back(int'(m[0])); expi.push_back(0);
    while (expm.size() < cap) begin
      reps = (d[k] == 8'd0) ? 1 : int'(d[k]);
      for (int r = 0; r < reps && expm.size() < cap; r++) begin
        expm.push_back(int'(m[k])); expi.push_back(k);
      end
      k++;
      if (k == 8 || m[k] == 4'd0) begin
        if (lp) k = 0;
        else break;
      end
    end
  endfunction

  task automatic play(input logic lp, input int stop_at, input logic exp_done);
    int   periods = 0;
    int   nexp;
    bit   got_done = 0;
    bit   stable_ok = 1;
    bit   finished = 0;
    logic [3:0] last_mode;
    nexp = expm.size();
    loop_en = lp; start = 1'b1;
    tick();
    start = 1'b0;
    last_mode = pg_mode;
    for (int budget = 0; budget < 3000 && !finished; budget++) begin
      if (done) begin
        got_done = 1; finished = 1;
        check("done_pg_rst", pg_rst, 1);
        check("done_pg_mode", pg_mode, 0);
        check("done_busy", busy, 0);
        check("done_periods", periods, nexp);
      end else if (!pg_rst && pg_count == 16'd1) begin
        periods++;
        if (expm.size() == 0) begin
          check("extra_period", periods, nexp);
          finished = 1;
        end else begin
          check("period_mode", pg_mode, expm.pop_front());
          check("period_idx", step_idx, expi.pop_front());
          check("period_busy", busy, 1);
        end
        if (stop_at != 0 && periods == stop_at) begin
          stop = 1'b1;
          tick();
          stop = 1'b0;
          check("stop_busy", busy, 0);
          check("stop_pg_rst", pg_rst, 1);
          check("stop_pg_mode", pg_mode, 0);
          check("stop_no_done", done, 0);
          finished = 1;
        end
      end else if (!pg_rst && pg_mode != last_mode) begin
        stable_ok = 0;
      end
      last_mode = pg_mode;
      if (!finished) tick();
    end
    if (!finished) begin
      total++; bad++;
      $display("FAIL run_timeout: got no end after 3000 cycles expected done or stop");
    end
    check("done_seen", got_done, exp_done);
    check("mode_only_at_boundary", stable_ok, 1);
    if (got_done) begin
      tick();
      check("done_one_cycle", done, 0);
    end
    tick();
  endtask

  task automatic use_vec(input int i);
    expm.delete(); expi.delete();
    for (int j = 0; j < int'(vecs[i].n); j++) begin
      expm.push_back(int'(vecs[i].ex[j][3:0]));
      expi.push_back(int'(vecs[i].ex[j][7:4]));
    end
  endtask

  initial begin
    logic [7:0][3:0] rm;
    logic [7:0][7:0] rd;
    logic            rlp;
    int              cap;
    int              pos;

    // Table: {4,dur2},{15,dur1},{0}
    vecs[0] = '0;
    vecs[0].m[0] = 4'd4; vecs[0].d[0] = 8'd2;
    vecs[0].m[1] = 4'd15; vecs[0].d[1] = 8'd1;
    vecs[0].n = 4'd4; vecs[0].exp_done = 1'b1;
    vecs[0].ex[0] = 8'h04; vecs[0].ex[1] = 8'h04; vecs[0].ex[2] = 8'h04; vecs[0].ex[3] = 8'h1F;
    // Same table looping, stopped after three passes
    vecs[1] = vecs[0];
    vecs[1].lp = 1'b1; vecs[1].stop_at = 4'd10; vecs[1].n = 4'd10; vecs[1].exp_done = 1'b0;
    vecs[1].ex[4] = 8'h04; vecs[1].ex[5] = 8'h04; vecs[1].ex[6] = 8'h1F;
    vecs[1].ex[7] = 8'h04; vecs[1].ex[8] = 8'h04; vecs[1].ex[9] = 8'h1F;
    // Full table, modes 1..8, all durations 0
    vecs[2] = '0;
    for (int i = 0; i < 8; i++) vecs[2].m[i] = 4'(i + 1);
    vecs[2].n = 4'd9; vecs[2].exp_done = 1'b1;
    vecs[2].ex[0] = 8'h01;
    for (int i = 0; i < 8; i++) vecs[2].ex[i+1] = {4'(i), 4'(i + 1)};
    // Empty program: entry 0 is the end marker
    vecs[3] = '0;
    vecs[3].m[1] = 4'd5; vecs[3].exp_done = 1'b1;
    // Stop during the first period of step 1
    vecs[4] = vecs[0];
    vecs[4].stop_at = 4'd4; vecs[4].exp_done = 1'b0;

    rst = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_mode = '0; wr_dur = '0;
    start = 1'b0; stop = 1'b0; loop_en = 1'b0; pg_count = '0;
    tick(); tick();
    check("reset_pg_mode", pg_mode, 0);
    check("reset_pg_rst", pg_rst, 1);
    check("reset_busy", busy, 0);
    check("reset_step_idx", step_idx, 0);
    check("reset_done", done, 0);
    check("reset_wr_err", wr_err, 0);
    rst = 1'b1;
    tick();
    check("post_reset_idle", busy, 0);

    for (int i = 0; i < 5; i++) begin
      per = (i == 2) ? 2 : 3;
      load(vecs[i].m, vecs[i].d);
      use_vec(i);
      play(vecs[i].lp, int'(vecs[i].stop_at), vecs[i].exp_done);
    end

    // start and stop together: stop wins
    per = 3;
    load(vecs[0].m, vecs[0].d);
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    check("start_stop_busy", busy, 0);
    check("start_stop_pg_rst", pg_rst, 1);
    tick();
    check("start_stop_no_done", done, 0);

    // write while busy is dropped and flagged
    loop_en = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_after_start", busy, 1);
    wr_en = 1'b1; wr_addr = 3'd1; wr_mode = 4'd9; wr_dur = 8'd5;
    tick();
    wr_en = 1'b0;
    check("wr_err_pulse", wr_err, 1);
    tick();
    check("wr_err_one_cycle", wr_err, 0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    tick();
    use_vec(1);
    void'(expm.pop_back()); void'(expi.pop_back());
    void'(expm.pop_back()); void'(expi.pop_back());
    void'(expm.pop_back()); void'(expi.pop_back());
    play(1'b1, 7, 1'b0);

    // start reads entry 0 as it was before a same-cycle write
    wr_en = 1'b1; wr_addr = 3'd0; wr_mode = 4'd7; wr_dur = 8'd2;
    loop_en = 1'b1; start = 1'b1;
    tick();
    wr_en = 1'b0; start = 1'b0;
    check("rbw_old_mode", pg_mode, 4);
    check("rbw_no_err", wr_err, 0);
    stop = 1'b1; tick(); stop = 1'b0; tick();
    start = 1'b1; tick(); start = 1'b0;
    check("rbw_new_mode", pg_mode, 7);
    stop = 1'b1; tick(); stop = 1'b0; tick();

    // randomized programs against the reference
    for (int it = 0; it < 8; it++) begin
      per = $urandom_range(2, 5);
      for (int i = 0; i < 8; i++) begin
        rm[i] = 4'($urandom_range(1, 15));
        rd[i] = 8'($urandom_range(0, 3));
      end
      pos = $urandom_range(1, 9);
      if (pos < 8) rm[pos] = 4'd0;
      rlp = 1'($urandom_range(0, 1));
      cap = rlp ? $urandom_range(3, 14) : 1000;
      load(rm, rd);
      build(rm, rd, rlp, cap);
      play(rlp, rlp ? cap : 0, !rlp);
    end

    // asynchronous reset in the middle of a run
    per = 3;
    load(vecs[0].m, vecs[0].d);
    loop_en = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    check("pre_async_busy", busy, 1);
    #2;
    rst = 1'b0;
    #1;
    check("async_pg_rst", pg_rst, 1);
    check("async_pg_mode", pg_mode, 0);
    check("async_busy", busy, 0);
    tick(); tick();
    check("async_hold_busy", busy, 0);
    rst = 1'b1;
    tick(); tick();
    check("async_release_busy", busy, 0);
    check("async_release_pg_rst", pg_rst, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
